// File: rtl/mips_operand_sequencer_if.sv
// Handshake and data bus bundle for mips_operand_sequencer.
//   Upstream instruction channel : instr_valid / instr_ready / instr
//   Register file read port      : rf_read_reg_0/1 -> rf_reg0/1 (registered, +1 cycle)
//   Register file write port     : rf_write / rf_write_reg / rf_write_data
//   ALU operand channel          : op_valid / op_ready / op_a / op_b / op_opcode / op_funct / op_shamt
//   ALU result channel           : res_valid / res_ready / res_data
//   Error pulses                 : err_illegal / err_timeout
// modport slave is the sequencer side; modport master is the environment around it.
interface mips_operand_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_read_reg_0;
  logic [4:0]  rf_read_reg_1;
  logic [31:0] rf_reg0;
  logic [31:0] rf_reg1;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  op_opcode;
  logic [5:0]  op_funct;
  logic [4:0]  op_shamt;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        err_illegal;
  logic        err_timeout;

  modport slave (
    input  instr_valid, instr, rf_reg0, rf_reg1, op_ready, res_valid, res_data,
    output instr_ready, rf_read_reg_0, rf_read_reg_1, rf_write, rf_write_reg,
           rf_write_data, op_valid, op_a, op_b, op_opcode, op_funct, op_shamt,
           res_ready, err_illegal, err_timeout
  );

  modport master (
    output instr_valid, instr, rf_reg0, rf_reg1, op_ready, res_valid, res_data,
    input  instr_ready, rf_read_reg_0, rf_read_reg_1, rf_write, rf_write_reg,
           rf_write_data, op_valid, op_a, op_b, op_opcode, op_funct, op_shamt,
           res_ready, err_illegal, err_timeout
  );
endinterface

// File: rtl/mips_operand_sequencer.sv
// Serialized decode / operand-fetch / writeback controller in front of the MIPS
// register file. One instruction at a time walks IDLE -> RD -> CAP -> ISSUE ->
// WAIT_RES -> WB -> IDLE.
// Ports:
//   cclk : clock, rising edge
//   rst  : asynchronous reset, active-high; aborts any instruction in flight
//   bus  : mips_operand_sequencer_if.slave (instruction, register file, ALU, errors)
// Parameter:
//   TIMEOUT_CYCLES : WAIT_RES cycles before giving up on a result (0 = wait forever)
module mips_operand_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     cclk,
  input  logic                     rst,
  mips_operand_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, ISSUE, WAIT_RES, WB} state_t;

  state_t      r_state;
  logic [5:0]  r_opcode;
  logic [15:0] r_imm;      // also carries rd/shamt/funct for R-type
  logic [4:0]  r_dest;
  logic [4:0]  r_rd0;
  logic [4:0]  r_rd1;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_rf_write;
  logic [4:0]  r_wr_reg;
  logic [31:0] r_wr_data;
  logic [15:0] r_cnt;
  logic        r_err_illegal;
  logic        r_err_timeout;

  logic [5:0]  w_opcode;
  logic        w_legal;
  logic [4:0]  w_dest;
  logic        w_expire;

  // Operand B: rt value for R-type, otherwise the immediate extended per opcode.
  function automatic logic [31:0] build_b(input logic [5:0] opc,
                                          input logic [15:0] imm,
                                          input logic [31:0] rt_val);
    logic [31:0] b;
    case (opc)
      6'h08, 6'h09, 6'h0A, 6'h0B: b = {{16{imm[15]}}, imm};
      6'h0C, 6'h0D, 6'h0E:        b = {16'h0000, imm};
      6'h0F:                      b = {imm, 16'h0000};
      default:                    b = rt_val;
    endcase
    return b;
  endfunction

  assign w_opcode = bus.instr[31:26];
  assign w_legal  = (w_opcode == 6'h00) || (w_opcode[5:3] == 3'b001);
  assign w_dest   = (w_opcode == 6'h00) ? bus.instr[15:11] : bus.instr[20:16];
  // Expiry is judged on the count this cycle would reach without a result.
  assign w_expire = (TIMEOUT_CYCLES != 0) &&
                    (({1'b0, r_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_opcode      <= '0;
      r_imm         <= '0;
      r_dest        <= '0;
      r_rd0         <= '0;
      r_rd1         <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_rf_write    <= 1'b0;
      r_wr_reg      <= '0;
      r_wr_data     <= '0;
      r_cnt         <= '0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_rf_write    <= 1'b0;
      case (r_state)
        // Accept edge: instr_ready is high throughout IDLE.
        IDLE: begin
          if (bus.instr_valid) begin
            if (w_legal) begin
              r_opcode <= w_opcode;
              r_imm    <= bus.instr[15:0];
              r_dest   <= w_dest;
              r_rd0    <= bus.instr[25:21];
              r_rd1    <= bus.instr[20:16];
              r_state  <= RD;
            end else begin
              // Illegal instruction is consumed without touching the register file.
              r_err_illegal <= 1'b1;
            end
          end
        end
        // Register file samples the read addresses at the end of RD.
        RD: r_state <= CAP;
        // Registered read data is valid here; capture the operand bundle.
        CAP: begin
          r_op_a  <= bus.rf_reg0;
          r_op_b  <= build_b(r_opcode, r_imm, bus.rf_reg1);
          r_state <= ISSUE;
        end
        // Bundle held stable until the ALU takes it.
        ISSUE: begin
          if (bus.op_ready) begin
            r_cnt   <= '0;
            r_state <= WAIT_RES;
          end
        end
        // A result arriving on the expiry cycle takes priority over the timeout.
        WAIT_RES: begin
          if (bus.res_valid) begin
            r_wr_data  <= bus.res_data;
            r_wr_reg   <= r_dest;
            r_rf_write <= (r_dest != 5'd0);
            r_state    <= WB;
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        // Write enable is high during WB and commits at its closing edge.
        WB: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.instr_ready   = (r_state == IDLE);
  assign bus.op_valid      = (r_state == ISSUE);
  assign bus.res_ready     = (r_state == WAIT_RES);
  assign bus.rf_read_reg_0 = r_rd0;
  assign bus.rf_read_reg_1 = r_rd1;
  assign bus.rf_write      = r_rf_write;
  assign bus.rf_write_reg  = r_wr_reg;
  assign bus.rf_write_data = r_wr_data;
  assign bus.op_a          = r_op_a;
  assign bus.op_b          = r_op_b;
  assign bus.op_opcode     = r_opcode;
  assign bus.op_funct      = r_imm[5:0];
  assign bus.op_shamt      = r_imm[10:6];
  assign bus.err_illegal   = r_err_illegal;
  assign bus.err_timeout   = r_err_timeout;

endmodule
